// File: rtl/mux_sel_ctrl_if.sv
// Pins between the select generator and the board/mux side: raw switch inputs,
// the mux select, and observation outputs.
interface mux_sel_ctrl_if;
    logic btn;
    logic auto_en;
    logic sel;
    logic sel_changed;
    logic btn_level;
    logic auto_mode;

    // Board or bench side: drives the raw inputs, observes the outputs.
    modport master (
        output btn,
        output auto_en,
        input  sel,
        input  sel_changed,
        input  btn_level,
        input  auto_mode
    );

    // Select generator side.
    modport slave (
        input  btn,
        input  auto_en,
        output sel,
        output sel_changed,
        output btn_level,
        output auto_mode
    );
endinterface

// File: rtl/mux_sel_ctrl.sv
// Select generator for the 2:1 mux: a debounced pushbutton toggles sel, and an
// optional auto mode toggles it every AUTO_PERIOD cycles.
module mux_sel_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned AUTO_PERIOD     = 8,
    parameter int unsigned CNT_W           = 20
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_sel_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(AUTO_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [1:0]       btn_sync, auto_sync;
    logic             btn_s, auto_s;
    logic [CNT_W-1:0] db_cnt, db_cnt_next;
    logic [CNT_W-1:0] per_cnt, per_cnt_next;
    logic             level_q, level_next;
    logic             sel_q, sel_changed_q;
    logic             press, toggle;

    assign btn_s  = btn_sync[1];
    assign auto_s = auto_sync[1];

    // Debounce: a level change is accepted on the DEBOUNCE_CYCLES-th
    // consecutive differing sample; any agreeing sample restarts the count.
    always_comb begin
        db_cnt_next = db_cnt;
        level_next  = level_q;
        if (btn_s == level_q) begin
            db_cnt_next = '0;
        end else if (db_cnt == DB_LAST) begin
            level_next  = btn_s;
            db_cnt_next = '0;
        end else begin
            db_cnt_next = db_cnt + CNT_ONE;
        end
    end

    // The press is taken from the accepting edge itself, so sel toggles on
    // the same edge that btn_level rises.
    assign press = level_next & ~level_q;

    always_comb begin
        state_next   = state;
        per_cnt_next = per_cnt;
        toggle       = 1'b0;
        case (state)
            MANUAL: begin
                per_cnt_next = '0;
                toggle       = press;
                if (auto_s) state_next = AUTO;
            end
            AUTO: begin
                if (!auto_s) begin
                    // Leaving auto: a pending expiry is dropped, only a press toggles.
                    state_next   = MANUAL;
                    per_cnt_next = '0;
                    toggle       = press;
                end else if (press || per_cnt == PER_LAST) begin
                    toggle       = 1'b1;
                    per_cnt_next = '0;
                end else begin
                    per_cnt_next = per_cnt + CNT_ONE;
                end
            end
            default: begin
                state_next   = MANUAL;
                per_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync      <= 2'b00;
            auto_sync     <= 2'b00;
            db_cnt        <= '0;
            per_cnt       <= '0;
            level_q       <= 1'b0;
            sel_q         <= 1'b0;
            sel_changed_q <= 1'b0;
            state         <= MANUAL;
        end else begin
            btn_sync      <= {btn_sync[0], bus.btn};
            auto_sync     <= {auto_sync[0], bus.auto_en};
            db_cnt        <= db_cnt_next;
            per_cnt       <= per_cnt_next;
            level_q       <= level_next;
            sel_q         <= sel_q ^ toggle;
            sel_changed_q <= toggle;
            state         <= state_next;
        end
    end

    assign bus.sel         = sel_q;
    assign bus.sel_changed = sel_changed_q;
    assign bus.btn_level   = level_q;
    assign bus.auto_mode   = (state == AUTO);

endmodule

// File: doc/mux_sel_ctrl.md
# mux_sel_ctrl

Clocked select generator for the 2:1 mux stage (`mux2t1`). It sits directly upstream of the mux and drives its `sel` input. A raw board pushbutton is synchronized and debounced, and each debounced press toggles `sel`. An optional auto mode toggles `sel` on a fixed period so both mux inputs can be observed hands-free.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive differing synchronized samples needed to accept a button level change. Legal range is 1 or more; use 1_000_000 on the board.
- `AUTO_PERIOD`, default 8: clock cycles between toggles in auto mode. Legal range is 2 or more.
- `CNT_W`, default 20: width of the debounce and period counters. Must hold max(`DEBOUNCE_CYCLES`, `AUTO_PERIOD`) - 1.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `btn`  in  1  raw pushbutton, asynchronous to `clk`, active-high.
- `auto_en`  in  1  raw slide switch, asynchronous; 1 selects auto mode.
- `sel`  out  1  registered select to the mux `sel` input.
- `sel_changed`  out  1  one-cycle pulse, high in the cycle after each `sel` change edge.
- `btn_level`  out  1  debounced button level, registered.

## Operation
- **Reset.** While `rst_n`=0, all of the following hold regardless of `clk`:
  - `sel`=0, `sel_changed`=0, `btn_level`=0.
  - Both synchronizer chains = 0, debounce count = 0, period count = 0.
  - State = MANUAL.
- **Synchronizers.** `btn` and `auto_en` each pass through a 2-flop synchronizer, giving `btn_s` and `auto_s`. No other logic samples the raw inputs.
- **Debounce.**
  - If `btn_s` == `btn_level`: debounce count <= 0.
  - If they differ and count < `DEBOUNCE_CYCLES`-1: count increments.
  - If they differ and count == `DEBOUNCE_CYCLES`-1: `btn_level` <= `btn_s` and count <= 0.
  - A glitch shorter than `DEBOUNCE_CYCLES` samples never changes `btn_level`.
- **Press event.** A press is the edge where `btn_level` goes 0->1. Release (1->0) generates no event.
- **State machine (2 states).**
  - MANUAL: `sel` toggles on each press. Period count is held at 0. Moves to AUTO on any edge where `auto_s`=1; period count <= 0 on that edge.
  - AUTO: period count increments each edge.
    - When it equals `AUTO_PERIOD`-1, `sel` toggles and the count wraps to 0.
    - A press also toggles `sel` and restarts the count at 0.
    - Moves to MANUAL on any edge where `auto_s`=0; `sel` holds its value and period count <= 0.
- **Simultaneous press and period expiry.** Exactly one toggle occurs and the period count <= 0.
- **Mode change in the same edge as a press.** The press toggles `sel` once. The new state's counter rules apply from the next edge.
- **`sel_changed`.** Registered: 1 for exactly the cycle following every edge at which `sel` changed, otherwise 0.

## Timing
- **Button latency.** `btn` goes high and stays high before edge E1. Then:
  - `btn_s`=1 after E2.
  - `btn_level`=1 and `sel` toggles at edge E(2+`DEBOUNCE_CYCLES`).
  - `sel_changed` is high for the cycle after that edge.
  - With defaults, `sel` toggles at E6.
- **Auto entry latency.** `auto_en` goes high before E1. Then:
  - `auto_s`=1 after E2.
  - State = AUTO at E3.
  - First auto toggle at E(3+`AUTO_PERIOD`), then every `AUTO_PERIOD` edges. With defaults: E11, E19, E27, and so on.
- **Reset mid-operation.** Outputs go to their reset values immediately (asynchronously). After `rst_n` rises, the first possible `sel` change is again 2+`DEBOUNCE_CYCLES` edges after a held press.
- **Throughput.** Accepted presses are at least 2·`DEBOUNCE_CYCLES` cycles apart (press plus release must both debounce).

## Test plan
1. **Reset.** Assert `rst_n`=0 mid-run with `sel`=1 and counters non-zero -> `sel`=0, `sel_changed`=0, `btn_level`=0 immediately. No toggle until a fresh debounced press.
2. **Clean press, defaults.** `btn` 0->1 held 10 cycles, then 0 -> `sel` 0->1 at E6, `sel_changed` high for 1 cycle. Release produces no toggle.
3. **Glitch rejection.** `btn` pulses high for 3 cycles, then low 10 cycles -> `btn_level` stays 0, `sel` stays 0, `sel_changed` never 1.
4. **Auto mode.** `auto_en`=1 from E0 for 30 cycles -> `sel` toggles at E11, E19, E27, with one `sel_changed` pulse after each. Dropping `auto_en` -> `sel` frozen at its last value.
5. **Press in auto, including simultaneous expiry.** Time a press so `btn_level` rises on the same edge the period count hits 7 -> exactly one toggle. The next auto toggle comes 8 edges later.
6. **Bounce train.** `btn` alternates every 2 cycles for 20 cycles, then holds 1 -> exactly one toggle, 6 edges after the final stable rise.
